voice_synth: RTL and testbench

Polyphonic square-wave tone generator placed directly downstream of the keyboard scanner. It consumes the scanner's note messages: a strobe plus an 8-bit word, where bit 7 = 1 means note-on, bit 7 = 0 means note-off, and bits 6:0 are the MIDI note number. It allocates each note-on to one of VOICES tone channels and generates each channel's half-period from a semitone table shifted by octave. It outputs the count of voices currently high, for the audio DAC/PWM stage that follows.

---
 rtl/voice_synth.sv | 218 +++++++++++++++++++++
 tb/tb_voice_synth.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/voice_synth.sv
// Polyphonic square-wave tone generator fed by keyboard-scanner note messages.
// Each note is split into semitone/octave, then given to a voice whose counter toggles a square output.
module voice_synth #(
  parameter int unsigned CLK_FREQ = 120_000_000,
  parameter int unsigned VOICES   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_msg,
  input  logic [7:0]        msg,
  output logic [2:0]        mix,
  output logic [VOICES-1:0] voice_active,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, DIV, ALLOC} state_e;

  function automatic logic [22:0] table_entry(input int s);
    real f;
    f = 16.351597831 * (2.0 ** (real'(s) / 12.0));
    return 23'($rtoi(real'(CLK_FREQ) / f + 0.5));
  endfunction

  localparam logic [22:0] TABLE [12] = '{
    table_entry(0), table_entry(1), table_entry(2),  table_entry(3),
    table_entry(4), table_entry(5), table_entry(6),  table_entry(7),
    table_entry(8), table_entry(9), table_entry(10), table_entry(11)
  };

  state_e            state_q, state_d;
  logic [2:0]        sync_q, sync_d;
  logic              strobe;
  logic [7:0]        msg_q, msg_d;
  logic [7:0]        pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic              overflow_q, overflow_d;
  logic [6:0]        rem_q, rem_d;
  logic [3:0]        oct_q, oct_d;
  logic [2:0]        steal_ptr_q, steal_ptr_d;
  logic [6:0]        note_q [VOICES];
  logic [6:0]        note_d [VOICES];
  logic [22:0]       hp_q   [VOICES];
  logic [22:0]       hp_d   [VOICES];
  logic [22:0]       cnt_q  [VOICES];
  logic [22:0]       cnt_d  [VOICES];
  logic [VOICES-1:0] sq_q, sq_d;
  logic [VOICES-1:0] active_q, active_d;
  logic [2:0]        mix_q, mix_d;

  logic              match_found, free_found;
  logic [2:0]        match_idx, free_idx, target;
  logic [22:0]       hp_new;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pend_valid_q || strobe) state_d = DIV;
      DIV:     if (rem_q < 7'd12) state_d = ALLOC;
      ALLOC:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    strobe = sync_q[1] & ~sync_q[2];
  end

  // Message capture, pending buffer and octave division
  always_comb begin
    sync_d       = {sync_q[1:0], clk_msg};
    msg_d        = msg_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    overflow_d   = overflow_q;
    rem_d        = rem_q;
    oct_d        = oct_q;
    if (state_q == IDLE) begin
      // Pending is older, so it goes first; a simultaneous strobe refills the slot.
      if (pend_valid_q) begin
        msg_d = pend_q;
        if (strobe) pend_d = msg;
        else        pend_valid_d = 1'b0;
      end else if (strobe) begin
        msg_d = msg;
      end
      rem_d = msg_d[6:0];
      oct_d = '0;
    end else begin
      if (strobe) begin
        if (!pend_valid_q) begin
          pend_d       = msg;
          pend_valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      if (state_q == DIV && rem_q >= 7'd12) begin
        rem_d = rem_q - 7'd12;
        oct_d = oct_q + 4'd1;
      end
    end
  end

  // Voice search for allocation
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int unsigned i = 0; i < VOICES; i++) begin
      if (!match_found && active_q[i] && note_q[i] == msg_q[6:0]) begin
        match_found = 1'b1;
        match_idx   = 3'(i);
      end
      if (!free_found && !active_q[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
    if (match_found)     target = match_idx;
    else if (free_found) target = free_idx;
    else                 target = steal_ptr_q;
    hp_new = TABLE[rem_q[3:0]] >> oct_q;
  end

  // Voice counters and table update
  always_comb begin
    note_d      = note_q;
    hp_d        = hp_q;
    steal_ptr_d = steal_ptr_q;
    mix_d       = '0;
    for (int unsigned i = 0; i < VOICES; i++) begin
      cnt_d[i]    = '0;
      sq_d[i]     = 1'b0;
      active_d[i] = active_q[i];
      if (active_q[i]) begin
        if (cnt_q[i] == hp_q[i] - 23'd1) begin
          cnt_d[i] = '0;
          sq_d[i]  = ~sq_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 23'd1;
          sq_d[i]  = sq_q[i];
        end
      end
      if (state_q == ALLOC) begin
        if (msg_q[7] && 3'(i) == target) begin
          note_d[i]   = msg_q[6:0];
          hp_d[i]     = hp_new;
          cnt_d[i]    = '0;
          sq_d[i]     = 1'b0;
          active_d[i] = 1'b1;
        end else if (!msg_q[7] && match_found && 3'(i) == match_idx) begin
          cnt_d[i]    = '0;
          sq_d[i]     = 1'b0;
          active_d[i] = 1'b0;
        end
      end
      mix_d = mix_d + {2'b00, sq_q[i] & active_q[i]};
    end
    if (state_q == ALLOC && msg_q[7] && !match_found && !free_found) begin
      steal_ptr_d = (steal_ptr_q == 3'(VOICES - 1)) ? '0 : steal_ptr_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      msg_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      rem_q        <= '0;
      oct_q        <= '0;
      steal_ptr_q  <= '0;
      sq_q         <= '0;
      active_q     <= '0;
      mix_q        <= '0;
      for (int unsigned i = 0; i < VOICES; i++) begin
        note_q[i] <= '0;
        hp_q[i]   <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      sync_q       <= sync_d;
      msg_q        <= msg_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      overflow_q   <= overflow_d;
      rem_q        <= rem_d;
      oct_q        <= oct_d;
      steal_ptr_q  <= steal_ptr_d;
      sq_q         <= sq_d;
      active_q     <= active_d;
      mix_q        <= mix_d;
      note_q       <= note_d;
      hp_q         <= hp_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mix          = mix_q;
  assign voice_active = active_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_voice_synth.sv
// Directed self-checking bench for voice_synth with a scaled-down clock frequency
// so that whole square periods fit in a short run (note 69 gives hp = 4364 >> 5 = 136).
module tb_voice_synth;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_msg;
  logic [7:0] msg;
  logic [2:0] mix;
  logic [3:0] voice_active;
  logic       busy;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  voice_synth #(
    .CLK_FREQ(120_000),
    .VOICES  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_msg      (clk_msg),
    .msg          (msg),
    .mix          (mix),
    .voice_active (voice_active),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Pulse clk_msg, wait for the message to be processed and check busy width (oct + 2).
  task automatic send(input logic [7:0] m, input int exp_width, input string tag);
    int  width;
    bit  done;
    msg = m;
    @(negedge clk);
    clk_msg = 1'b1;
    width = 0;
    done  = 1'b0;
    for (int i = 1; i <= 60 && !done; i++) begin
      @(negedge clk);
      if (i == 3) clk_msg = 1'b0;
      if (busy) width++;
      else if (width > 0) done = 1'b1;
    end
    clk_msg = 1'b0;
    check({tag, " busy width"}, width, exp_width);
  endtask

  task automatic wait_mix(input logic lvl, output int cycles);
    cycles = 0;
    while (mix !== {2'b00, lvl} && cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    clk_msg = 1'b0;
    msg     = '0;
    repeat (3) @(negedge clk);
    check("reset mix", mix, 0);
    check("reset voice_active", voice_active, 0);
    check("reset busy", busy, 0);
    check("reset overflow", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single note 69: hp = 136, first mix rise 137 cycles after the table update.
    send(8'hC5, 7, "on69");
    check("on69 voice_active", voice_active, 4'b0001);
    wait_mix(1'b1, n);
    check("on69 first rise", n, 137);
    wait_mix(1'b0, n);
    check("on69 high time", n, 136);
    wait_mix(1'b1, n);
    check("on69 low time", n, 136);

    // Retrigger while high: square restarts from 0.
    send(8'hC5, 7, "retrig69");
    check("retrig69 voice_active", voice_active, 4'b0001);
    check("retrig69 mix before", mix, 1);
    @(negedge clk);
    check("retrig69 mix cleared", mix, 0);
    wait_mix(1'b1, n);
    check("retrig69 rise", n + 1, 137);

    send(8'h45, 7, "off69");
    check("off69 voice_active", voice_active, 4'b0000);
    @(negedge clk);
    check("off69 mix", mix, 0);

    // Fill, retrigger, steal, note-off.
    pulse_rst();
    send(8'hBC, 7, "on60");
    check("on60 voice_active", voice_active, 4'b0001);
    send(8'hC0, 7, "on64");
    check("on64 voice_active", voice_active, 4'b0011);
    send(8'hC3, 7, "on67");
    check("on67 voice_active", voice_active, 4'b0111);
    send(8'hC7, 7, "on71");
    check("on71 voice_active", voice_active, 4'b1111);
    send(8'hC0, 7, "retrig64");
    check("retrig64 voice_active", voice_active, 4'b1111);
    send(8'hC8, 8, "on72 steal");
    check("on72 voice_active", voice_active, 4'b1111);
    send(8'hCA, 8, "on74 steal");
    check("on74 voice_active", voice_active, 4'b1111);
    send(8'h40, 7, "off64 stolen");
    check("off64 voice_active", voice_active, 4'b1111);
    send(8'h4A, 8, "off74");
    check("off74 voice_active", voice_active, 4'b1101);
    send(8'h48, 8, "off72");
    check("off72 voice_active", voice_active, 4'b1100);
    send(8'h32, 6, "off50 unheld");
    check("off50 voice_active", voice_active, 4'b1100);
    send(8'h43, 7, "off67");
    check("off67 voice_active", voice_active, 4'b1000);
    send(8'h47, 7, "off71");
    check("off71 voice_active", voice_active, 4'b0000);
    @(negedge clk);
    check("all off mix", mix, 0);
    check("no overflow yet", overflow, 0);

    // Three strobes in one busy window: first runs, second pends, third dropped.
    pulse_rst();
    for (int k = 0; k < 60; k++) begin
      case (k)
        0:  begin msg = 8'hFF; clk_msg = 1'b1; end
        3:  clk_msg = 1'b0;
        5:  begin msg = 8'hFE; clk_msg = 1'b1; end
        8:  clk_msg = 1'b0;
        10: begin msg = 8'hFD; clk_msg = 1'b1; end
        13: clk_msg = 1'b0;
        default: ;
      endcase
      @(negedge clk);
    end
    check("burst busy", busy, 0);
    check("burst voice_active", voice_active, 4'b0011);
    check("burst overflow", overflow, 1);
    send(8'hBC, 7, "post-burst on60");
    check("post-burst voice_active", voice_active, 4'b0111);
    check("overflow sticky", overflow, 1);
    send(8'h7F, 12, "off127");
    check("off127 voice_active", voice_active, 4'b0110);

    // Reset during DIV of note 127.
    msg = 8'hFF;
    @(negedge clk);
    clk_msg = 1'b1;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    clk_msg = 1'b0;
    check("div busy seen", busy, 1);
    repeat (3) @(negedge clk);
    check("still in div", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("mid rst busy", busy, 0);
    check("mid rst voice_active", voice_active, 0);
    check("mid rst mix", mix, 0);
    check("mid rst overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'hC5, 7, "after rst on69");
    check("after rst voice_active", voice_active, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
